// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: icache lookup/result, redirect input and instruction-queue head.
// The fetch unit drives through master; the icache/decoder side connects to slave.
`timescale 1ns/1ps

interface ifetch_unit_if;
  // icache lookup side
  logic        to_icache;
  logic [31:0] pc;
  logic        have_result;
  logic [31:0] inst;

  // redirect side
  logic        flush;
  logic [31:0] flush_pc;

  // decoder side
  logic        iq_ready;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_is_c;

  modport master (
    output to_icache, pc, iq_valid, iq_inst, iq_pc, iq_is_c,
    input  have_result, inst, flush, flush_pc, iq_ready
  );

  modport slave (
    input  to_icache, pc, iq_valid, iq_inst, iq_pc, iq_is_c,
    output have_result, inst, flush, flush_pc, iq_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding icache lookups,
// sizes RV32C/RV32 instructions and queues {pc, inst} for the decoder.
`timescale 1ns/1ps

module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IQ_WIDTH = 2,
  parameter int          IQ_DEPTH = 1 << IQ_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  ifetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_c;
  } iq_entry_t;

  localparam logic [IQ_WIDTH:0] FULL_COUNT = (IQ_WIDTH + 1)'(IQ_DEPTH);

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         pend_q, pend_d;
  logic                req_q, req_d;

  iq_entry_t           iq_mem [IQ_DEPTH];
  logic [IQ_WIDTH-1:0] head_q, tail_q;
  logic [IQ_WIDTH:0]   count_q;

  logic                push, pop, iq_full, iq_nonempty;
  logic                fetch_is_c;
  logic [31:0]         flush_target;
  iq_entry_t           push_entry, head_entry;

  assign flush_target = {bus.flush_pc[31:1], 1'b0};
  assign fetch_is_c   = (bus.inst[1:0] != 2'b11);
  assign push_entry   = '{pc:   pc_q,
                          inst: fetch_is_c ? {16'h0000, bus.inst[15:0]} : bus.inst,
                          is_c: fetch_is_c};

  assign iq_full     = (count_q == FULL_COUNT);
  assign iq_nonempty = (count_q != '0);
  assign pop         = iq_nonempty && bus.iq_ready && !bus.flush;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    req_d   = 1'b0;
    push    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          pc_d = flush_target;
        end else if (!iq_full) begin
          req_d   = 1'b1;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (bus.flush) begin
          if (bus.have_result) begin
            pc_d    = flush_target;
            state_d = IDLE;
          end else begin
            // The refill still indexes by pc, so the redirect is parked until it lands.
            pend_d  = flush_target;
            state_d = DROP;
          end
        end else if (bus.have_result) begin
          push    = 1'b1;
          pc_d    = pc_q + (fetch_is_c ? 32'd2 : 32'd4);
          state_d = IDLE;
        end
      end

      DROP: begin
        if (bus.have_result) begin
          pc_d    = bus.flush ? flush_target : pend_q;
          state_d = IDLE;
        end else if (bus.flush) begin
          pend_d = flush_target;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      req_q   <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
    end
  end

  // A redirect empties the queue and takes priority over a same-cycle push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      if (bus.flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + 1'b1;
        if (pop)  head_q <= head_q + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // NOTE: queue storage has no reset; outputs are masked by occupancy so stale entries never leak.
  always_ff @(posedge clk) begin
    if (rdy && push) iq_mem[tail_q] <= push_entry;
  end

  assign head_entry    = iq_mem[head_q];

  assign bus.to_icache = req_q;
  assign bus.pc        = pc_q;
  assign bus.iq_valid  = iq_nonempty;
  assign bus.iq_inst   = iq_nonempty ? head_entry.inst : '0;
  assign bus.iq_pc     = iq_nonempty ? head_entry.pc   : '0;
  assign bus.iq_is_c   = iq_nonempty && head_entry.is_c;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a randomized run checked against
// a program-order model (expected pc/inst sequence derived from a halfword memory).
`timescale 1ns/1ps

module tb_ifetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;

  always #5 clk = ~clk;

  ifetch_unit_if bus ();

  ifetch_unit #(
    .RESET_PC (32'h0000_0000),
    .IQ_WIDTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.master)
  );

  int          n_checks = 0;
  int          n_pass   = 0;

  // icache model: one lookup tracked, answered after lat cycles
  bit          out_pend = 1'b0;
  int          out_cnt  = 0;
  logic [31:0] out_pc   = '0;
  int          lat      = 1;

  // Halfword memory seen by the icache.
  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h100) return 16'h4501;
    if (a == 32'h102) return 16'h0093;
    if (a == 32'h104) return 16'h0010;
    if (a < 32'h40)   return a[1] ? 16'h00A0 : {a[11:0], 4'h3};
    h = a * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    return h[15:0];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {hw(a + 32'd2), hw(a)};
  endfunction

  function automatic logic exp_c(input logic [31:0] a);
    logic [15:0] h;
    h = hw(a);
    return h[1:0] != 2'b11;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    return exp_c(a) ? {16'h0000, hw(a)} : word_at(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive the icache response for this cycle, then advance to edge+1.
  task automatic tick();
    bus.have_result = 1'b0;
    bus.inst        = $urandom;
    if (out_pend) begin
      out_cnt--;
      if (out_cnt == 0) begin
        bus.have_result = 1'b1;
        bus.inst        = word_at(out_pc);
        out_pend        = 1'b0;
      end
    end
    if (bus.to_icache) begin
      out_pend = 1'b1;
      out_cnt  = lat;
      out_pc   = bus.pc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    tick();
    while (!bus.to_icache && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_req"}, {31'b0, bus.to_icache}, 32'd1);
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    rdy             = 1'b1;
    bus.flush       = 1'b0;
    bus.flush_pc    = '0;
    bus.iq_ready    = 1'b0;
    bus.have_result = 1'b0;
    bus.inst        = '0;
    out_pend        = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int          npulse;
    int          last_cyc;
    int          n_pops;
    logic [31:0] exp_pc;

    // ---- reset state, then 32-bit hits with the decoder stalled ----
    do_reset();
    check("rst_pc",        bus.pc,                   32'h0);
    check("rst_to_icache", {31'b0, bus.to_icache},   32'd0);
    check("rst_iq_valid",  {31'b0, bus.iq_valid},    32'd0);
    check("rst_iq_inst",   bus.iq_inst,              32'h0);
    check("rst_iq_pc",     bus.iq_pc,                32'h0);
    check("rst_iq_is_c",   {31'b0, bus.iq_is_c},     32'd0);

    lat      = 1;
    npulse   = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.to_icache) begin
        check("fill_pc", bus.pc, 32'(npulse * 4));
        if (npulse > 0) check("fill_gap", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        npulse++;
      end
      tick();
    end
    check("fill_pulses", 32'(npulse), 32'd4);
    check("fill_head_pc",   bus.iq_pc,   32'h0);
    check("fill_head_inst", bus.iq_inst, 32'h00A0_0003);

    // ---- redirect while idle and full, then a mixed C / 32-bit stream ----
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h100;
    tick();
    bus.flush    = 1'b0;
    check("idle_flush_valid", {31'b0, bus.iq_valid},  32'd0);
    check("idle_flush_pc",    bus.pc,                 32'h100);
    check("idle_flush_noreq", {31'b0, bus.to_icache}, 32'd0);
    wait_req("mix0");
    check("mix0_pc", bus.pc, 32'h100);
    wait_req("mix1");
    check("mix1_pc", bus.pc, 32'h102);
    check("mix_head_pc",   bus.iq_pc,             32'h100);
    check("mix_head_inst", bus.iq_inst,           32'h0000_4501);
    check("mix_head_c",    {31'b0, bus.iq_is_c},  32'd1);
    wait_req("mix2");
    check("mix_next_pc", bus.pc, 32'h106);
    bus.iq_ready = 1'b1;
    tick();
    bus.iq_ready = 1'b0;
    check("mix_2nd_pc",   bus.iq_pc,            32'h102);
    check("mix_2nd_inst", bus.iq_inst,          32'h0010_0093);
    check("mix_2nd_c",    {31'b0, bus.iq_is_c}, 32'd0);

    // ---- miss with a redirect during WAIT ----
    do_reset();
    lat = 10;
    wait_req("miss");
    check("miss_req_pc", bus.pc, 32'h0);
    tick();
    tick();
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h200;
    tick();
    bus.flush    = 1'b0;
    check("miss_flush_valid", {31'b0, bus.iq_valid}, 32'd0);
    for (int n = 0; n < 20 && out_pend; n++) begin
      check("miss_pc_hold", bus.pc, 32'h0);
      tick();
    end
    check("miss_returned", {31'b0, out_pend}, 32'd0);
    wait_req("miss_restart");
    check("miss_restart_pc", bus.pc,                32'h200);
    check("miss_not_pushed", {31'b0, bus.iq_valid}, 32'd0);

    // ---- redirect coincident with a hit and a pending pop ----
    do_reset();
    lat = 1;
    wait_req("coin0");
    wait_req("coin1");
    check("coin_pre_valid", {31'b0, bus.iq_valid}, 32'd1);
    tick();
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h301;
    bus.iq_ready = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.iq_ready = 1'b0;
    check("coin_valid", {31'b0, bus.iq_valid},  32'd0);
    check("coin_pc",    bus.pc,                 32'h300);
    check("coin_noreq", {31'b0, bus.to_icache}, 32'd0);
    tick();
    check("coin_req",    {31'b0, bus.to_icache}, 32'd1);
    check("coin_req_pc", bus.pc,                 32'h300);

    // ---- push and pop in the same cycle, then fill and drain in order ----
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) wait_req("pp_fill");
    check("pp_fill_pc", bus.pc, 32'd12);
    tick();
    check("pp_head_before", bus.iq_pc, 32'd0);
    bus.iq_ready = 1'b1;
    tick();
    bus.iq_ready = 1'b0;
    check("pp_head_after", bus.iq_pc, 32'd4);
    wait_req("pp_last");
    check("pp_last_pc", bus.pc, 32'd16);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      check("pp_full_noreq", {31'b0, bus.to_icache}, 32'd0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check("pp_order", bus.iq_pc, 32'(4 + 4 * i));
      bus.iq_ready = 1'b1;
      tick();
      bus.iq_ready = 1'b0;
    end

    // ---- randomized run against the program-order model ----
    do_reset();
    exp_pc = 32'h0;
    n_pops = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (out_pend)      check("rnd_pc_hold", bus.pc, out_pc);
      if (bus.to_icache) check("rnd_one_in_flight", {31'b0, out_pend}, 32'd0);
      lat          = $urandom_range(1, 4);
      bus.flush    = ($urandom_range(0, 24) == 0);
      bus.flush_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                 : (32'h1000 + ($urandom & 32'h3FFF));
      bus.iq_ready = $urandom_range(0, 1);
      if (bus.flush) begin
        exp_pc = {bus.flush_pc[31:1], 1'b0};
      end else if (bus.iq_valid && bus.iq_ready) begin
        check("rnd_iq_pc",   bus.iq_pc,            exp_pc);
        check("rnd_iq_inst", bus.iq_inst,          exp_inst(exp_pc));
        check("rnd_iq_is_c", {31'b0, bus.iq_is_c}, {31'b0, exp_c(exp_pc)});
        exp_pc = exp_pc + (exp_c(exp_pc) ? 32'd2 : 32'd4);
        n_pops++;
      end
      tick();
    end
    bus.flush    = 1'b0;
    bus.iq_ready = 1'b0;
    check("rnd_progress", {31'b0, (n_pops > 200)}, 32'd1);

    // ---- rdy stall mid-WAIT, then asynchronous reset mid-WAIT ----
    do_reset();
    lat = 1;
    wait_req("stall0");
    lat = 10;
    wait_req("stall1");
    tick();
    tick();
    rdy          = 1'b0;
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h500;
    bus.iq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_pc",        bus.pc,                 32'd4);
      check("stall_to_icache", {31'b0, bus.to_icache}, 32'd0);
      check("stall_valid",     {31'b0, bus.iq_valid},  32'd1);
      check("stall_iq_pc",     bus.iq_pc,              32'h0);
      check("stall_iq_inst",   bus.iq_inst,            32'h00A0_0003);
    end
    rdy          = 1'b1;
    bus.flush    = 1'b0;
    bus.iq_ready = 1'b0;
    tick();
    #2;
    rst      = 1'b0;
    out_pend = 1'b0;
    #1;
    check("arst_pc",        bus.pc,                 32'h0);
    check("arst_to_icache", {31'b0, bus.to_icache}, 32'd0);
    check("arst_valid",     {31'b0, bus.iq_valid},  32'd0);
    check("arst_iq_inst",   bus.iq_inst,            32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("arst_restart", {31'b0, bus.to_icache}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
